// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter and its
// round-robin picker: default widths, FSM states and the rr_pick helper.
package regfile_pkg;

  localparam int NUM_ADDR_BITS_DEF = 6;
  localparam int REG_WIDTH_DEF     = 32;
  localparam int REG_ZERO_ADDR     = 0;

  // rr_pick works on a fixed 8-wide vector so one function serves any NUM_REQ <= 8
  localparam int PICK_MAX   = 8;
  localparam int PICK_IDX_W = 3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arbState_e;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid[0:numReq-1] at or after ptr, wrapping around.
  // Scans offsets high to low so the smallest offset is the last to win.
  function automatic pick_t rr_pick(input logic [PICK_MAX-1:0]   valid,
                                    input logic [PICK_IDX_W-1:0] ptr,
                                    input int                    numReq);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = numReq - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= numReq) cand = cand - numReq;
      if (valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand[PICK_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select over NUM_REQ requesters.
// Reusable by any port scheduler that keeps its own rotating pointer.
module rr_picker
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);

  logic [PICK_MAX-1:0]   validExt;
  logic [PICK_IDX_W-1:0] ptrExt;
  pick_t                 pick;

  // Widen to the package function's fixed width, pick, then one-hot the result
  always_comb begin
    validExt              = '0;
    validExt[NUM_REQ-1:0] = valid;
    ptrExt                = PICK_IDX_W'(ptr);
    pick                  = rr_pick(validExt, ptrExt, NUM_REQ);
    found                 = pick.found;
    idx                   = PTR_W'(pick.idx);
    grant                 = '0;
    if (pick.found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 3R/1W register file. Round-robin between
// requesters, with burst locking capped at MAX_BURST grants. The write
// port outputs are registered so they are stable for the negedge commit.
// Optional sticky same-address hazard flag: REGFILE_WR_ARB_COLLIDE_EN.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int NUM_ADDR_BITS = NUM_ADDR_BITS_DEF,
  parameter int REG_WIDTH     = REG_WIDTH_DEF,
  parameter int MAX_BURST     = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*NUM_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_we,
  output logic [NUM_ADDR_BITS-1:0]       rf_wr_addr,
  output logic [REG_WIDTH-1:0]           rf_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           locked
`ifdef REGFILE_WR_ARB_COLLIDE_EN
  ,
  output logic                           collide
`endif
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arbState_e               state, stateNxt;
  logic [OWN_W-1:0]        rrPtr, rrPtrNxt, ownerNxt;
  logic [CNT_W-1:0]        burstCnt, burstNxt;
  logic [NUM_REQ-1:0]      pickGrant, grant;
  logic [OWN_W-1:0]        pickIdx, gntIdx;
  logic                    pickFound;
  logic                    xfer;

  logic [NUM_REQ-1:0][NUM_ADDR_BITS-1:0] addrArr;
  logic [NUM_REQ-1:0][REG_WIDTH-1:0]     dataArr;
  logic [NUM_ADDR_BITS-1:0]              selAddr;

  assign addrArr = req_addr;
  assign dataArr = req_data;
  assign selAddr = addrArr[gntIdx];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (OWN_W)
  ) uPicker (
    .valid (req_valid),
    .ptr   (rrPtr),
    .grant (pickGrant),
    .idx   (pickIdx),
    .found (pickFound)
  );

  // State register: FSM, RR pointer, owner and burst count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB;
      rrPtr    <= '0;
      owner    <= '0;
      burstCnt <= '0;
    end else begin
      state    <= stateNxt;
      rrPtr    <= rrPtrNxt;
      owner    <= ownerNxt;
      burstCnt <= burstNxt;
    end
  end

  // Next state: lock on a locked ARB grant, release on lock=0, owner drop or burst cap
  always_comb begin
    stateNxt = state;
    rrPtrNxt = rrPtr;
    ownerNxt = owner;
    burstNxt = burstCnt;
    if (xfer) begin
      ownerNxt = gntIdx;
      rrPtrNxt = (gntIdx == OWN_W'(NUM_REQ - 1)) ? '0 : gntIdx + 1'b1;
    end
    case (state)
      ARB: begin
        if (xfer && req_lock[gntIdx]) begin
          stateNxt = LOCKED;
          burstNxt = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!req_valid[owner]) begin
          stateNxt = ARB;
          burstNxt = '0;
        end else if (xfer) begin
          if (!req_lock[owner] || burstCnt == CNT_W'(MAX_BURST - 1)) begin
            stateNxt = ARB;
            burstNxt = '0;
          end else begin
            burstNxt = burstCnt + 1'b1;
          end
        end
      end
      default: stateNxt = ARB;
    endcase
  end

  // Grant outputs: picker result in ARB, owner only in LOCKED, nothing in reset
  always_comb begin
    grant  = '0;
    gntIdx = pickIdx;
    if (!reset_n) begin
      grant = '0;
    end else if (state == LOCKED) begin
      gntIdx        = owner;
      grant[owner]  = req_valid[owner];
    end else if (pickFound) begin
      grant = pickGrant;
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign locked    = (state == LOCKED);

  // Write port register; address 0 completes the handshake but never writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_we <= xfer && (selAddr != NUM_ADDR_BITS'(REG_ZERO_ADDR));
      if (xfer) begin
        rf_wr_addr <= selAddr;
        rf_wr_data <= dataArr[gntIdx];
      end
    end
  end

`ifdef REGFILE_WR_ARB_COLLIDE_EN
  logic collideNow;

  // Any two valid requesters aiming at the same nonzero register
  always_comb begin
    collideNow = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (req_valid[i] && req_valid[j] && addrArr[i] == addrArr[j] &&
            addrArr[i] != NUM_ADDR_BITS'(REG_ZERO_ADDR))
          collideNow = 1'b1;
      end
    end
  end

  // Sticky hazard flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) collide <= 1'b0;
    else          collide <= collide | collideNow;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural model checked
// every negedge, queue-driven requesters and literal expectations.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_lock = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;
  logic [1:0]        owner;
  logic              locked;
`ifdef REGFILE_WR_ARB_COLLIDE_EN
  logic              collide;
`endif

  regfile_wr_arbiter #(
    .NUM_REQ(N), .NUM_ADDR_BITS(AW), .REG_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .owner(owner), .locked(locked)
`ifdef REGFILE_WR_ARB_COLLIDE_EN
    , .collide(collide)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file seen by the arbiter ----------------
  logic [DW-1:0] rfMem [64] = '{default: '0};
  always @(negedge clk) if (rf_we) rfMem[rf_wr_addr] <= rf_wr_data;

  // ---------------- requester queues ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lock;
    logic          gap;
  } item_t;

  item_t        rq [N][$];
  logic [N-1:0] seenX  = '0;
  logic [N-1:0] drvGap = '0;
  int           gntLog [$];

  task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic l, input logic g);
    item_t it;
    it.addr = a; it.data = d; it.lock = l; it.gap = g;
    rq[i].push_back(it);
  endtask

  // Requesters: retire the head after a handshake (or a one-cycle gap), then present the next
  initial begin
    item_t h;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++)
        if (rq[i].size() > 0 && (seenX[i] || drvGap[i])) void'(rq[i].pop_front());
      #1;
      for (int i = 0; i < N; i++) begin
        drvGap[i] = 1'b0;
        if (rq[i].size() == 0) begin
          req_valid[i] = 1'b0;
          req_lock[i]  = 1'b0;
        end else begin
          h = rq[i][0];
          if (h.gap) begin
            req_valid[i] = 1'b0;
            req_lock[i]  = 1'b0;
            drvGap[i]    = 1'b1;
          end else begin
            req_valid[i]           = 1'b1;
            req_lock[i]            = h.lock;
            req_addr[i*AW +: AW]   = h.addr;
            req_data[i*DW +: DW]   = h.data;
          end
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic          mLocked = 1'b0;
  int            mOwner  = 0;
  int            mPtr    = 0;
  int            mBurst  = 0;
  logic          mWe     = 1'b0;
  logic [AW-1:0] mAddr   = '0;
  logic [DW-1:0] mData   = '0;
  logic          mCol    = 1'b0;
  int            mPick;
  logic          mColNow;

  function automatic int modelPick(input logic rn, input logic [N-1:0] v,
                                   input logic lk, input int own, input int ptr);
    int c;
    if (!rn) return -1;
    if (lk) return v[own] ? own : -1;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic colNow(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (v[i] && v[j] && a[i*AW +: AW] == a[j*AW +: AW] && a[i*AW +: AW] != '0)
          return 1'b1;
    return 1'b0;
  endfunction

  always_comb mPick   = modelPick(reset_n, req_valid, mLocked, mOwner, mPtr);
  always_comb mColNow = colNow(req_valid, req_addr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mLocked <= 1'b0; mOwner <= 0; mPtr <= 0; mBurst <= 0;
      mWe <= 1'b0; mAddr <= '0; mData <= '0; mCol <= 1'b0;
    end else begin
      mCol <= mCol | mColNow;
      if (mPick >= 0) begin
        mWe    <= (req_addr[mPick*AW +: AW] != '0);
        mAddr  <= req_addr[mPick*AW +: AW];
        mData  <= req_data[mPick*DW +: DW];
        mOwner <= mPick;
        mPtr   <= (mPick + 1) % N;
        if (mLocked) begin
          if (!req_lock[mPick] || mBurst + 1 >= MB) begin
            mLocked <= 1'b0; mBurst <= 0;
          end else begin
            mBurst <= mBurst + 1;
          end
        end else if (req_lock[mPick]) begin
          mLocked <= 1'b1; mBurst <= 1;
        end
      end else begin
        mWe <= 1'b0;
        if (mLocked && !req_valid[mOwner]) begin
          mLocked <= 1'b0; mBurst <= 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [N-1:0]    expRdy;
    logic [N-1:0]    prevV = '0;
    logic [N-1:0]    prevR = '0;
    logic [N*AW-1:0] prevA = '0;
    logic [N*DW-1:0] prevD = '0;
    forever begin
      @(negedge clk);
      expRdy = '0;
      if (mPick >= 0) expRdy[mPick] = 1'b1;
      chk("ready", req_ready, expRdy);
      chk("rf_we", rf_we, mWe);
      chk("rf_wr_addr", rf_wr_addr, mAddr);
      chk("rf_wr_data", rf_wr_data, mData);
      chk("owner", owner, mOwner);
      chk("locked", locked, mLocked);
`ifdef REGFILE_WR_ARB_COLLIDE_EN
      chk("collide", collide, mCol);
`endif
      // waiting requesters must hold their payload
      for (int i = 0; i < N; i++) begin
        if (reset_n && prevV[i] && !prevR[i] && req_valid[i]) begin
          chk("hold_addr", req_addr[i*AW +: AW], prevA[i*AW +: AW]);
          chk("hold_data", req_data[i*DW +: DW], prevD[i*DW +: DW]);
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) gntLog.push_back(i);
      seenX = req_valid & req_ready;
      prevV = req_valid; prevR = req_ready; prevA = req_addr; prevD = req_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic flushQueues();
    for (int i = 0; i < N; i++) rq[i].delete();
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    flushQueues();
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    gntLog.delete();
  endtask

  task automatic waitLog(input int n, input int budget);
    int c = 0;
    while (gntLog.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("grant_count_reached", (gntLog.size() >= n), 1'b1);
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size()) != 0 && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("queues_drained", rq[0].size() + rq[1].size() + rq[2].size(), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic chkLog(input string name, input int idx, input int exp);
    if (gntLog.size() > idx) chk(name, gntLog[idx], exp);
    else                     chk(name, 64'hFFFF, exp);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cnt;
    // reset state
    @(posedge clk); #1;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_addr", rf_wr_addr, 0);
    chk("rst_data", rf_wr_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ready", req_ready, 3'b000);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // single request
    @(negedge clk);
    push(0, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("t1_ready", req_ready, 3'b001);
    @(posedge clk); #2;
    chk("t1_we", rf_we, 1'b1);
    chk("t1_addr", rf_wr_addr, 6'd5);
    chk("t1_data", rf_wr_data, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("t1_regfile5", rfMem[5], 32'hDEADBEEF);

    // three contending requesters, round robin
    doReset();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push(i, 6'(i + 1), 32'h100 + 32'(16 * i + k), 1'b0, 1'b0);
    waitLog(6, 40);
    for (int j = 0; j < 6; j++) chkLog("t2_order", j, j % 3);
    waitIdle(20);

    // burst lock capped at MAX_BURST with a stalled requester
    doReset();
    @(negedge clk);
    for (int k = 0; k < 20; k++) push(2, 6'(10 + k), 32'h2000 + 32'(k), 1'b1, 1'b0);
    waitLog(1, 10);
    push(0, 6'd4, 32'h000000A0, 1'b0, 1'b0);
    waitLog(21, 100);
    cnt = 0;
    for (int j = 0; j < 16; j++) if (gntLog.size() > j && gntLog[j] == 2) cnt++;
    chk("t3_burst_of_2", cnt, 16);
    chkLog("t3_after_release", 16, 0);
    cnt = 0;
    for (int j = 17; j < 21; j++) if (gntLog.size() > j && gntLog[j] == 2) cnt++;
    chk("t3_tail_of_2", cnt, 4);
    waitIdle(20);

    // release by lock=0
    doReset();
    @(negedge clk);
    push(1, 6'd20, 32'h11, 1'b1, 1'b0);
    push(1, 6'd21, 32'h12, 1'b0, 1'b0);
    push(1, 6'd22, 32'h13, 1'b1, 1'b0);
    waitLog(1, 10);
    push(0, 6'd23, 32'h14, 1'b0, 1'b0);
    waitLog(4, 20);
    chkLog("t4_g0", 0, 1); chkLog("t4_g1", 1, 1);
    chkLog("t4_g2", 2, 0); chkLog("t4_g3", 3, 1);
    waitIdle(20);

    // release by owner dropping valid for one cycle
    doReset();
    @(negedge clk);
    push(1, 6'd24, 32'h21, 1'b1, 1'b0);
    push(1, 6'd25, 32'h22, 1'b1, 1'b0);
    push(1, 6'd0,  32'h0,  1'b0, 1'b1);
    push(1, 6'd26, 32'h23, 1'b0, 1'b0);
    waitLog(1, 10);
    push(0, 6'd27, 32'h24, 1'b0, 1'b0);
    waitLog(4, 20);
    chkLog("t5_g0", 0, 1); chkLog("t5_g1", 1, 1);
    chkLog("t5_g2", 2, 0); chkLog("t5_g3", 3, 1);
    waitIdle(20);

    // address 0 handshakes but does not write
    doReset();
    @(negedge clk);
    push(1, 6'd0, 32'h00001234, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("t6_ready", req_ready, 3'b010);
    @(posedge clk); #2;
    chk("t6_we", rf_we, 1'b0);
    @(negedge clk); #1;
    chk("t6_regfile0", rfMem[0], 0);

    // reset in the middle of a locked burst
    doReset();
    @(negedge clk);
    for (int k = 0; k < 10; k++) push(2, 6'(30 + k), 32'h3000 + 32'(k), 1'b1, 1'b0);
    waitLog(4, 20);
    @(posedge clk); #2;
    chk("t7_we_before", rf_we, 1'b1);
    reset_n = 1'b0;
    flushQueues();
    #1;
    chk("t7_we", rf_we, 1'b0);
    chk("t7_locked", locked, 1'b0);
    chk("t7_ready", req_ready, 3'b000);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    gntLog.delete();
    @(negedge clk);
    push(2, 6'd40, 32'h41, 1'b1, 1'b0);
    push(0, 6'd41, 32'h42, 1'b0, 1'b0);
    waitLog(1, 10);
    chkLog("t7_first_after_reset", 0, 0);
    waitIdle(20);

`ifdef REGFILE_WR_ARB_COLLIDE_EN
    // same nonzero address from two requesters
    doReset();
    chk("t8_col_reset", collide, 1'b0);
    @(negedge clk);
    push(0, 6'd7, 32'h71, 1'b0, 1'b0);
    push(1, 6'd7, 32'h72, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("t8_col_not_yet", collide, 1'b0);
    @(posedge clk); #2;
    chk("t8_col_set", collide, 1'b1);
    waitIdle(20);
    chk("t8_col_sticky", collide, 1'b1);
    // same address 0 never flags
    doReset();
    chk("t8_col_cleared", collide, 1'b0);
    @(negedge clk);
    push(0, 6'd0, 32'h81, 1'b0, 1'b0);
    push(1, 6'd0, 32'h82, 1'b0, 1'b0);
    waitIdle(20);
    chk("t8_col_addr0", collide, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
